frame_buffer_db: RTL and testbench

// Double-buffered single-clock frame buffer, parametrised in resolution and pixel width, addressed by (x,y).

---
 rtl/frame_buffer_db_if.sv | 40 ++++
 rtl/frame_buffer_db.sv | 154 +++++++++++++++
 tb/tb_frame_buffer_db.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_db_if.sv
// Renderer / scan-out side bundle for the double-buffered frame buffer.
// The master drives coordinates and strobes; the slave is the buffer itself.
interface frame_buffer_db_if #(
   parameter int PIX_W = 8,
   parameter int X_W   = 10,
   parameter int Y_W   = 10
);
   logic [X_W-1:0]   wr_x;
   logic [Y_W-1:0]   wr_y;
   logic [PIX_W-1:0] wr_data;
   logic             wr_en;
   logic             wr_ready;
   logic [X_W-1:0]   rd_x;
   logic [Y_W-1:0]   rd_y;
   logic             rd_en;
   logic [PIX_W-1:0] rd_data;
   logic             rd_valid;
   logic             frame_start;
   logic             swap_req;
   logic             swap_pending;
   logic             swap_done;
   logic             front_sel;
   logic             clear_req;
   logic [PIX_W-1:0] clear_value;
   logic             clear_busy;

   modport master (
      output wr_x, wr_y, wr_data, wr_en, rd_x, rd_y, rd_en,
             frame_start, swap_req, clear_req, clear_value,
      input  wr_ready, rd_data, rd_valid, swap_pending, swap_done,
             front_sel, clear_busy
   );

   modport slave (
      input  wr_x, wr_y, wr_data, wr_en, rd_x, rd_y, rd_en,
             frame_start, swap_req, clear_req, clear_value,
      output wr_ready, rd_data, rd_valid, swap_pending, swap_done,
             front_sel, clear_busy
   );
endinterface

// File: rtl/frame_buffer_db.sv
// Double-buffered (x,y) frame buffer: renderer writes the back bank, scan-out reads
// the front bank, banks swap on frame_start; a clear engine fills the back bank.
//
// state    | meaning
// SW_IDLE  | no swap outstanding
// SW_PEND  | swap requested, waiting for frame_start with clear engine idle
// CL_IDLE  | clear engine idle, renderer writes accepted
// CL_RUN   | clear engine writing one back-bank word per cycle
module frame_buffer_db #(
   parameter int               H_RES    = 640,
   parameter int               V_RES    = 480,
   parameter int               PIX_W    = 8,
   parameter int               X_W      = 10,
   parameter int               Y_W      = 10,
   parameter logic [PIX_W-1:0] BG_VALUE = '0
) (
   input logic              clk,
   input logic              rst_n,
   frame_buffer_db_if.slave bus
);
   localparam int DEPTH = H_RES * V_RES;
   localparam int A_W   = $clog2(2 * DEPTH);

   typedef logic [A_W-1:0] addr_t;
   typedef enum logic { SW_IDLE, SW_PEND } sw_state_t;
   typedef enum logic { CL_IDLE, CL_RUN } cl_state_t;

   function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (int'(x) < H_RES) && (int'(y) < V_RES);
   endfunction

   // Bank 1 occupies the upper DEPTH words; out-of-range coordinates map to 0.
   function automatic addr_t lin_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                      input logic bank);
      if (!in_range(x, y)) return '0;
      return addr_t'(y) * addr_t'(H_RES) + addr_t'(x) + (bank ? addr_t'(DEPTH) : addr_t'(0));
   endfunction

   logic [PIX_W-1:0] mem [2*DEPTH];

   sw_state_t        sw_q, sw_d;
   logic             front_q, front_d;
   logic             done_q, done_d;
   cl_state_t        cl_q, cl_d;
   addr_t            cl_addr_q, cl_addr_d;
   addr_t            cl_left_q, cl_left_d;
   logic [PIX_W-1:0] cl_val_q, cl_val_d;
   logic             wr_v_q, wr_v_d;
   addr_t            wr_a_q, wr_a_d;
   logic [PIX_W-1:0] wr_dat_q, wr_dat_d;
   logic             rd_v_q, rd_v_d;
   logic             rd_inr_q, rd_inr_d;
   addr_t            rd_a_q, rd_a_d;
   logic [PIX_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             wr_fire;

   assign wr_fire = bus.wr_en && (cl_q == CL_IDLE);

   always_comb begin
      sw_d       = sw_q;
      front_d    = front_q;
      done_d     = 1'b0;
      cl_d       = cl_q;
      cl_addr_d  = cl_addr_q;
      cl_left_d  = cl_left_q;
      cl_val_d   = cl_val_q;
      wr_v_d     = wr_fire && in_range(bus.wr_x, bus.wr_y);
      wr_a_d     = lin_addr(bus.wr_x, bus.wr_y, ~front_q);
      wr_dat_d   = bus.wr_data;
      rd_v_d     = bus.rd_en;
      rd_inr_d   = in_range(bus.rd_x, bus.rd_y);
      rd_a_d     = lin_addr(bus.rd_x, bus.rd_y, front_q);
      rd_valid_d = rd_v_q;
      rd_data_d  = rd_data_q;

      if (rd_v_q) rd_data_d = rd_inr_q ? mem[rd_a_q] : BG_VALUE;

      // A swap requested in the same cycle as it executes is absorbed, not re-armed.
      if (bus.frame_start && sw_q == SW_PEND && cl_q == CL_IDLE) begin
         front_d = ~front_q;
         sw_d    = SW_IDLE;
         done_d  = 1'b1;
      end else if (bus.swap_req) begin
         sw_d = SW_PEND;
      end

      case (cl_q)
         CL_IDLE: if (bus.clear_req) begin
            cl_d      = CL_RUN;
            cl_val_d  = bus.clear_value;
            cl_addr_d = front_q ? addr_t'(0) : addr_t'(DEPTH);
            cl_left_d = addr_t'(DEPTH - 1);
         end
         CL_RUN: begin
            cl_addr_d = cl_addr_q + addr_t'(1);
            cl_left_d = cl_left_q - addr_t'(1);
            if (cl_left_q == '0) cl_d = CL_IDLE;
         end
         default: cl_d = CL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q       <= SW_IDLE;
         front_q    <= 1'b0;
         done_q     <= 1'b0;
         cl_q       <= CL_IDLE;
         cl_addr_q  <= '0;
         cl_left_q  <= '0;
         cl_val_q   <= '0;
         wr_v_q     <= 1'b0;
         wr_a_q     <= '0;
         wr_dat_q   <= '0;
         rd_v_q     <= 1'b0;
         rd_inr_q   <= 1'b0;
         rd_a_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         sw_q       <= sw_d;
         front_q    <= front_d;
         done_q     <= done_d;
         cl_q       <= cl_d;
         cl_addr_q  <= cl_addr_d;
         cl_left_q  <= cl_left_d;
         cl_val_q   <= cl_val_d;
         wr_v_q     <= wr_v_d;
         wr_a_q     <= wr_a_d;
         wr_dat_q   <= wr_dat_d;
         rd_v_q     <= rd_v_d;
         rd_inr_q   <= rd_inr_d;
         rd_a_q     <= rd_a_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // A renderer write landing in the first clear cycle targets the same bank and
   // would be overwritten by the fill anyway, so the clear port simply wins.
   always_ff @(posedge clk) begin
      if (cl_q == CL_RUN)   mem[cl_addr_q] <= cl_val_q;
      else if (wr_v_q)      mem[wr_a_q]    <= wr_dat_q;
   end

   assign bus.wr_ready     = (cl_q == CL_IDLE);
   assign bus.clear_busy   = (cl_q == CL_RUN);
   assign bus.swap_pending = (sw_q == SW_PEND);
   assign bus.swap_done    = done_q;
   assign bus.front_sel    = front_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
endmodule

// File: tb/tb_frame_buffer_db.sv
// Directed plus randomized bench for frame_buffer_db at 8x4 resolution, checked
// against a two-bank array model of the pixel store and swap/clear rules.
module tb_frame_buffer_db;
   localparam int H = 8;
   localparam int V = 4;
   localparam int N = H * V;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   frame_buffer_db_if #(.PIX_W(8), .X_W(10), .Y_W(10)) bus ();

   frame_buffer_db #(
      .H_RES(H), .V_RES(V), .PIX_W(8), .X_W(10), .Y_W(10), .BG_VALUE(8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] mm [2][N];
   int         m_front = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input int x, input int y);
      if (x < H && y < V) return mm[m_front][y*H + x];
      return 8'h00;
   endfunction

   task automatic wr(input int x, input int y, input logic [7:0] d);
      bus.wr_x = 10'(x); bus.wr_y = 10'(y); bus.wr_data = d; bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      if (x < H && y < V) mm[1-m_front][y*H + x] = d;
   endtask

   task automatic rd(input int x, input int y, input string tag);
      bus.rd_x = 10'(x); bus.rd_y = 10'(y); bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      tick();
      chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
      chk(tag, 32'(bus.rd_data), 32'(model_read(x, y)));
   endtask

   task automatic frame_swap(input string tag);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      m_front = 1 - m_front;
      chk({tag, "_front"}, 32'(bus.front_sel), 32'(m_front));
      chk({tag, "_done"}, 32'(bus.swap_done), 32'd1);
      chk({tag, "_pend_clr"}, 32'(bus.swap_pending), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(bus.swap_done), 32'd0);
   endtask

   task automatic do_swap(input string tag);
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk({tag, "_pend"}, 32'(bus.swap_pending), 32'd1);
      frame_swap(tag);
   endtask

   task automatic do_clear(input logic [7:0] val, input bit swap_during);
      int n;
      bus.clear_value = val; bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      chk("clr_busy", 32'(bus.clear_busy), 32'd1);
      chk("clr_wr_ready", 32'(bus.wr_ready), 32'd0);
      n = 0;
      while (bus.clear_busy === 1'b1 && n < 200) begin
         n++;
         bus.wr_en       = 1'b1;
         bus.wr_x        = 10'($urandom_range(0, H-1));
         bus.wr_y        = 10'($urandom_range(0, V-1));
         bus.wr_data     = ~val;
         bus.clear_req   = (n == 3);
         bus.clear_value = ~val;
         bus.swap_req    = swap_during && (n == 5);
         bus.frame_start = swap_during && (n == 10);
         tick();
         if (swap_during && n == 10) begin
            chk("swap_in_clear_front", 32'(bus.front_sel), 32'(m_front));
            chk("swap_in_clear_pend", 32'(bus.swap_pending), 32'd1);
         end
      end
      bus.wr_en = 1'b0; bus.clear_req = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
      chk("clr_cycles", 32'(n), 32'(N));
      for (int i = 0; i < N; i++) mm[1-m_front][i] = val;
   endtask

   initial begin
      bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
      bus.rd_x = '0; bus.rd_y = '0; bus.rd_en = 1'b0;
      bus.frame_start = 1'b0; bus.swap_req = 1'b0;
      bus.clear_req = 1'b0; bus.clear_value = '0;

      tick(); tick();
      chk("rst_front", 32'(bus.front_sel), 32'd0);
      chk("rst_pend", 32'(bus.swap_pending), 32'd0);
      chk("rst_done", 32'(bus.swap_done), 32'd0);
      chk("rst_busy", 32'(bus.clear_busy), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);

      // Bring both banks to known contents.
      do_clear(8'h11, 1'b0);
      do_swap("init_swap0");
      do_clear(8'h22, 1'b0);
      do_swap("init_swap1");

      wr(3, 2, 8'hA5);
      do_swap("t2_swap");
      rd(3, 2, "t2_rd_a5");
      rd(0, 0, "t2_rd_other");

      wr(8, 0, 8'hFF);
      wr(2, 1, 8'h5A);
      do_swap("t3_swap");
      rd(8, 0, "t3_rd_oob");
      rd(0, 1, "t3_rd_no_alias");
      rd(2, 1, "t3_rd_5a");
      tick();
      chk("t3_valid_low", 32'(bus.rd_valid), 32'd0);
      chk("t3_data_hold", 32'(bus.rd_data), 32'h5A);

      for (int k = 0; k < 40; k++) begin
         wr($urandom_range(0, H+1), $urandom_range(0, V+1), 8'($urandom));
         if ($urandom_range(0, 1) == 1) tick();
      end
      do_swap("rand_swap");
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) rd(x, y, "rand_rd");
      for (int k = 0; k < 4; k++) rd($urandom_range(H, H+5), $urandom_range(0, V+3), "rand_rd_oob");

      do_clear(8'h3C, 1'b1);
      chk("t5_pend_after_clear", 32'(bus.swap_pending), 32'd1);
      frame_swap("t5_swap");
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) rd(x, y, "t4_rd_3c");

      bus.swap_req = 1'b1; bus.frame_start = 1'b1;
      tick();
      bus.swap_req = 1'b0; bus.frame_start = 1'b0;
      chk("t6_no_swap_front", 32'(bus.front_sel), 32'(m_front));
      chk("t6_no_swap_done", 32'(bus.swap_done), 32'd0);
      chk("t6_pend", 32'(bus.swap_pending), 32'd1);
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk("t6_repeat_absorbed", 32'(bus.swap_pending), 32'd1);
      frame_swap("t6_swap");
      tick();
      chk("t6_single_toggle", 32'(bus.front_sel), 32'(m_front));

      // Reset in the middle of a clear with a read result and a swap outstanding.
      bus.clear_value = 8'h77; bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      tick(); tick();
      bus.rd_x = 10'd1; bus.rd_y = 10'd1; bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0; bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk("t1_pre_valid", 32'(bus.rd_valid), 32'd1);
      chk("t1_pre_data", 32'(bus.rd_data), 32'(model_read(1, 1)));
      chk("t1_pre_busy", 32'(bus.clear_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t1_async_busy", 32'(bus.clear_busy), 32'd0);
      chk("t1_async_valid", 32'(bus.rd_valid), 32'd0);
      chk("t1_async_data", 32'(bus.rd_data), 32'd0);
      chk("t1_async_pend", 32'(bus.swap_pending), 32'd0);
      chk("t1_async_front", 32'(bus.front_sel), 32'd0);
      chk("t1_async_done", 32'(bus.swap_done), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t1_post_busy", 32'(bus.clear_busy), 32'd0);
      chk("t1_post_pend", 32'(bus.swap_pending), 32'd0);
      chk("t1_post_ready", 32'(bus.wr_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
